// File: rtl/seq_1110_pkg.sv
// seq_1110_pkg: shared state encoding and framing constants for the 1110 sync link
package seq_1110_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, STUFF} state_t;
    localparam logic [3:0] PREAMBLE = 4'b1110;
    localparam int         PRE_LEN  = 4;
    localparam logic [1:0] ONES_MAX = 2'd2;
endpackage

// File: rtl/seq_1110_framer.sv
// seq_1110_framer: serial transmitter sending a 1110 preamble then a bit-stuffed payload word
module seq_1110_framer
    import seq_1110_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         tx,
    output logic         tx_en,
    output logic         done
);
    localparam int BW = $clog2(W + 1);
    // r_state names the kind of bit currently on tx, so IDLE is the gap cycle
    state_t       r_state;
    logic [W-1:0] r_sreg;
    logic [BW-1:0] r_bits;
    logic [1:0]   r_ones;
    logic [1:0]   r_pidx;
    logic         r_tx;
    logic         r_tx_en;
    logic         r_done;
    logic         w_bit;
    logic [1:0]   w_ones_nx;
    logic         w_last;
    logic         w_stuff;
    logic         w_load;
    logic         w_end;
    always_comb begin
        w_bit     = r_sreg[W-1];
        w_ones_nx = w_bit ? r_ones + 2'd1 : 2'd0;
        w_last    = (r_bits == BW'(1)) && (w_ones_nx != ONES_MAX);
        w_stuff   = (r_state == DATA) && (r_ones == ONES_MAX);
        w_load    = (r_state == PRE && r_pidx == 2'(PRE_LEN - 1)) ||
                    (r_bits != '0 && ((r_state == DATA && !w_stuff) || r_state == STUFF));
        w_end     = (r_bits == '0) && ((r_state == DATA && !w_stuff) || r_state == STUFF);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_bits  <= '0;
            r_ones  <= '0;
            r_pidx  <= '0;
            r_tx    <= 1'b0;
            r_tx_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_state <= DATA;
                r_tx    <= w_bit;
                r_sreg  <= r_sreg << 1;
                r_bits  <= r_bits - BW'(1);
                r_ones  <= w_ones_nx;
                r_done  <= w_last;
            end else if (w_stuff) begin
                r_state <= STUFF;
                r_tx    <= 1'b0;
                r_ones  <= '0;
                r_done  <= (r_bits == '0);
            end else if (w_end) begin
                r_state <= IDLE;
                r_tx    <= 1'b0;
                r_tx_en <= 1'b0;
            end else if (r_state == PRE) begin
                r_pidx <= r_pidx + 2'd1;
                r_tx   <= PREAMBLE[2'd2 - r_pidx];
            end else if (r_state == IDLE && valid_in) begin
                r_state <= PRE;
                r_tx    <= PREAMBLE[PRE_LEN-1];
                r_tx_en <= 1'b1;
                r_pidx  <= '0;
                r_sreg  <= data_in;
                r_bits  <= BW'(W);
                r_ones  <= '0;
            end
        end
    end
    assign ready_out = (r_state == IDLE) && !rst;
    assign tx        = r_tx;
    assign tx_en     = r_tx_en;
    assign done      = r_done;
endmodule

// File: tb/tb_seq_1110_framer.sv
// tb_seq_1110_framer: queue-based frame model, per-cycle compare, destuffer and 1110 detector
module tb_seq_1110_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, tx, tx_en, done;
    int errors = 0;
    int checks = 0;

    seq_1110_framer #(.W(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .tx_en(tx_en), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a right-aligned bit string, first bit most significant; returns its length
    function automatic int frame_of(input logic [7:0] w, output logic [31:0] bits);
        int n = 4;
        int ones = 0;
        bits = 32'hE;
        for (int i = 7; i >= 0; i--) begin
            bits = {bits[30:0], w[i]};
            n++;
            ones = w[i] ? ones + 1 : 0;
            if (ones == 2) begin
                bits = {bits[30:0], 1'b0};
                n++;
                ones = 0;
            end
        end
        return n;
    endfunction

    logic        m_valid = 1'b0;
    logic        m_cur = 1'b0;
    logic        m_q[$];
    logic [7:0]  words[$];
    logic [31:0] m_fb;
    int          m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_q.delete();
            words.delete();
        end else if (!m_valid) begin
            if (valid_in) begin
                m_n = frame_of(data_in, m_fb);
                for (int i = m_n - 1; i >= 0; i--) m_q.push_back(m_fb[i]);
                m_cur = m_q.pop_front();
                m_valid = 1'b1;
                words.push_back(data_in);
            end
        end else if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
        end else begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("tx", tx, m_valid ? m_cur : 1'b0);
        chk("tx_en", tx_en, m_valid);
        chk("done", done, m_valid && m_q.size() == 0);
        chk("ready_out", ready_out, !m_valid && !rst);
    end

    task automatic check_frame(input logic [31:0] c, input int len);
        logic [7:0] w = 8'h00;
        logic [7:0] exp;
        logic       b;
        int ones = 0, nb = 0, det = 0, dpos = -1, run = 0;
        for (int i = 0; i < len; i++) begin
            b = c[len-1-i];
            if (b) run = (run < 3) ? run + 1 : 3;
            else begin
                if (run == 3) begin
                    det++;
                    if (dpos < 0) dpos = i;
                end
                run = 0;
            end
            if (i >= 4) begin
                if (ones == 2) begin
                    chk("stuff_bit", b, 1'b0);
                    ones = 0;
                end else begin
                    w = {w[6:0], b};
                    nb++;
                    ones = b ? ones + 1 : 0;
                end
            end
        end
        exp = (words.size() > 0) ? words.pop_front() : 8'hxx;
        chk("payload", w, exp);
        chk("payload_bits", nb, 8);
        chk("det_matches", det, 1);
        chk("det_pos", dpos, 3);
    endtask

    logic [31:0] cap = 0, last_cap = 0;
    int cap_len = 0, last_len = 0, nframes = 0, idle_run = 100, last_gap = 0;

    always @(negedge clk) begin
        if (rst) begin
            cap = 0;
            cap_len = 0;
        end else if (tx_en) begin
            if (cap_len == 0) last_gap = idle_run;
            idle_run = 0;
            cap = {cap[30:0], tx};
            cap_len++;
            if (done) begin
                last_cap = cap;
                last_len = cap_len;
                nframes++;
                check_frame(cap, cap_len);
                cap = 0;
                cap_len = 0;
            end
        end else begin
            idle_run++;
        end
    end

    task automatic send_one(input logic [7:0] w);
        @(posedge clk);
        #1;
        data_in = w;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        for (int i = 0; i < 100 && nframes < target; i++) @(posedge clk);
        chk("frame_timeout", nframes >= target, 1'b1);
    endtask

    initial begin
        logic [31:0] fb;
        int n, target;
        n = frame_of(8'hF6, fb);
        chk("model_F6", fb, 32'h76CC);
        chk("model_F6_len", n, 15);
        n = frame_of(8'hFF, fb);
        chk("model_FF", fb, 32'hEDB6);
        chk("model_FF_len", n, 16);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1'b0);
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", ready_out, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", ready_out, 1'b1);
        send_one(8'h00);
        wait_frame(1);
        chk("frame_00", last_cap, 32'hE00);
        chk("frame_00_len", last_len, 12);
        send_one(8'hF6);
        wait_frame(2);
        chk("frame_F6", last_cap, 32'h76CC);
        chk("frame_F6_len", last_len, 15);
        send_one(8'hFF);
        wait_frame(3);
        chk("frame_FF", last_cap, 32'hEDB6);
        chk("frame_FF_len", last_len, 16);
        @(posedge clk);
        #1;
        data_in = 8'hA5;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        data_in = 8'h3C;
        wait_frame(4);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        wait_frame(5);
        chk("b2b_gap", last_gap, 1);
        send_one(8'hFF);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1'b0);
        chk("midrst_tx_en", tx_en, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_ready", ready_out, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_midrst", ready_out, 1'b1);
        send_one(8'h5A);
        wait_frame(6);
        chk("frame_5A", last_cap, 32'h1CB2);
        chk("frame_5A_len", last_len, 13);
        for (int k = 0; k < 1000; k++) begin
            target = nframes + 1;
            send_one(8'($urandom));
            wait_frame(target);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_1110_framer.md
# seq_1110_framer

Serial frame transmitter that emits the 1110 synchronisation pattern followed by a bit-stuffed payload. It is the transmit end of the 1110 sync link: the non-overlapping 1110 Mealy detector on the far end locks onto the preamble. Bit stuffing guarantees the payload can never reproduce 1110, so the detector cannot false-sync mid-frame. The block sits between a parallel word source (valid/ready) and the single-wire serial line.

## Interface
- W, 8: payload width in bits, W ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  W  payload word, sampled on handshake.
- valid_in  in  1  source has a word.
- ready_out  out  1  framer can accept; equals (state==IDLE) && !rst.
- tx  out  1  serial line, registered, 0 when idle.
- tx_en  out  1  registered, high for every bit belonging to a frame.
- done  out  1  registered one-cycle pulse coinciding with the last frame bit on tx.

## Operation
- Handshake: a word is accepted on the rising edge where valid_in && ready_out. data_in is copied into the shift register, and the ones counter is cleared.
- States:
  - IDLE: tx=0, tx_en=0. On accept, go to PRE.
  - PRE: drives 1,1,1,0 on four consecutive cycles (2-bit index), then goes to DATA.
  - DATA: drives the shift-register MSB, then shifts left and decrements the bit counter.
  - STUFF: drives one 0.
  - From DATA or STUFF, the next state is STUFF if two consecutive 1s were just sent. Otherwise it is DATA if payload bits remain, or IDLE if none remain.
- Stuffing rule:
  - ones_cnt counts consecutive payload 1s sent. It is cleared by any 0 sent (data or stuff) and at frame start.
  - When ones_cnt reaches 2, exactly one stuff 0 follows immediately, including after the final payload bit.
- Frame length is 4 + W + S cycles, where S is the number of stuff bits (0 ≤ S ≤ W/2). No 1110 occurs anywhere in a frame except the preamble.
- valid_in and data_in are ignored outside IDLE. A word is never lost or duplicated.
- Reset (any time, including mid-frame): state=IDLE, tx=0, tx_en=0, done=0, ready_out=0 while rst is high. The partial frame is abandoned and not resumed.

## Timing
- Accept at edge k:
  - Preamble bits appear on tx in cycles k+1..k+4.
  - The first payload bit appears in cycle k+5.
- done=1 and tx_en=1 in the same cycle as the last frame bit. In the following cycle the state is IDLE, ready_out=1, and tx=0.
- Back-to-back frames are separated by exactly one idle cycle (tx=0, tx_en=0) when valid_in stays high.
- Reset values: tx=0, tx_en=0, done=0, ready_out=0 (1 after rst deasserts).
- Throughput is one bit per cycle. There is no stall input, and a frame, once started, always completes.

## Structure
- Package seq_1110_pkg holds:
  - the state enum {IDLE, PRE, DATA, STUFF};
  - PREAMBLE = 4'b1110 and PRE_LEN = 4;
  - the ones-count threshold constant (2).
- Single module, no sub-modules. The stuffing decision is local combinational logic on ones_cnt and the current bit.

## Test plan
- Word 8'h00, valid held one cycle: tx = 1110 00000000 (12 cycles). done is high on cycle 12 after accept. ready_out=0 throughout and returns to 1 on cycle 13.
- Word 8'hF6: tx = 1110 11011001100 (15 cycles, S=3). The detector model reports exactly one match, at preamble bit 4.
- Word 8'hFF: tx = 1110 110110110110 (16 cycles). The frame ends with a stuff 0, and done aligns with that stuff bit.
- valid_in held high with words 8'hA5 and 8'h3C: the two frames are separated by exactly one tx=0/tx_en=0 cycle. The decoded payloads, after removing each 0 that follows two 1s, equal A5 and 3C.
- rst pulsed during payload bit 3 of 8'hFF: tx, tx_en and done are 0 immediately. ready_out is 1 after release. The next accepted word produces a complete, correct frame.
- Random words (1000 frames, W=8): a reference destuffer recovers every word, and the 1110 detector never fires outside preamble positions.
